// File: rtl/controle_sequencia_param.sv
// controle_sequencia_param: Moore control unit for the memory-sequence game (play-back timing,
//   response timeout, sequence/address counters, optional difficulty level).
// Latency: iniciar -> preparacao next cycle -> leds_on one cycle later; a play is compared 2 cycles after tem_jogada.
// Backpressure: none; tem_jogada is a one-cycle pulse that is ignored outside espera_jogada.
//
// Optional feature macro: NIVEL_EN (when defined, i_nivel=0 halves the sequence length).
//
// Ports:
//   i_clock, i_reset (async, active-high)  - clock and reset (reset forces state inicial)
//   i_iniciar                              - start/restart request, level-sampled
//   i_nivel                                - difficulty (1 full, 0 half), only with NIVEL_EN
//   i_tem_jogada                           - one-cycle pulse: player input present
//   i_jogadaIgualMemoria                   - registered play equals memory[endereco]
//   o_endereco                             - sequence-memory address (counter E)
//   o_limite                               - index of last element of current round (counter S)
//   o_zeraR / o_registraR                  - clear / load the play register
//   o_leds_en                              - show memory[endereco] on the LEDs
//   o_estado_espera                        - waiting for a player input
//   o_acertou, o_errou, o_timeout, o_pronto - end flags
//   o_db_estado                            - state code for debug
module controle_sequencia_param #(
  parameter int ADDR_W = 4,
  parameter int T_ON   = 1000,
  parameter int T_OFF  = 500,
  parameter int T_MAX  = 5000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_iniciar,
  input  logic              i_nivel,
  input  logic              i_tem_jogada,
  input  logic              i_jogadaIgualMemoria,
  output logic [ADDR_W-1:0] o_endereco,
  output logic [ADDR_W-1:0] o_limite,
  output logic              o_zeraR,
  output logic              o_registraR,
  output logic              o_leds_en,
  output logic              o_estado_espera,
  output logic              o_acertou,
  output logic              o_errou,
  output logic              o_timeout,
  output logic              o_pronto,
  output logic [3:0]        o_db_estado
);

  // Timer only has to reach the largest of the three terminal counts minus one.
  localparam int T_ONOFF = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int T_BIG   = (T_ONOFF > T_MAX) ? T_ONOFF : T_MAX;
  localparam int TMR_W   = (T_BIG > 1) ? $clog2(T_BIG) : 1;

  localparam logic [TMR_W-1:0] TON_LAST  = TMR_W'(T_ON - 1);
  localparam logic [TMR_W-1:0] TOFF_LAST = TMR_W'(T_OFF - 1);
  localparam logic [TMR_W-1:0] TMAX_LAST = TMR_W'(T_MAX - 1);

  localparam logic [ADDR_W-1:0] LAST_FULL = '1;
  localparam logic [ADDR_W-1:0] LAST_HALF = LAST_FULL >> 1;

  typedef enum logic [3:0] {
    S_INICIAL           = 4'h0,
    S_PREPARACAO        = 4'h1,
    S_INICIA_SEQUENCIA  = 4'h2,
    S_ESPERA_JOGADA     = 4'h3,
    S_REGISTRA          = 4'h4,
    S_COMPARACAO        = 4'h5,
    S_PROXIMO           = 4'h6,
    S_PROXIMA_SEQUENCIA = 4'h8,
    S_LEDS_ON           = 4'h9,
    S_FINAL_ACERTO      = 4'hA,
    S_LEDS_OFF          = 4'hB,
    S_FINAL_TIMEOUT     = 4'hC,
    S_PROXIMO_LED       = 4'hD,
    S_FINAL_ERRO        = 4'hE,
    S_ZERA_ENDERECO     = 4'hF
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [TMR_W-1:0]   r_timer;
  logic [ADDR_W-1:0]  r_e;
  logic [ADDR_W-1:0]  r_s;
  logic [ADDR_W-1:0]  w_last;
  logic               w_timer_run;

`ifdef NIVEL_EN
  // Difficulty is captured once per game so mid-game toggles of i_nivel are harmless.
  logic r_nivel;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_nivel <= 1'b1;
    end else if (r_state == S_PREPARACAO) begin
      r_nivel <= i_nivel;
    end
  end

  assign w_last = r_nivel ? LAST_FULL : LAST_HALF;
`else
  logic w_unused_nivel;
  assign w_unused_nivel = i_nivel;
  assign w_last         = LAST_FULL;
`endif

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_INICIAL;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INICIAL:           if (i_iniciar) w_next = S_PREPARACAO;
      S_PREPARACAO:        w_next = S_LEDS_ON;
      S_LEDS_ON:           if (r_timer == TON_LAST) w_next = S_LEDS_OFF;
      S_LEDS_OFF: begin
        if (r_timer == TOFF_LAST) begin
          w_next = (r_e == r_s) ? S_ZERA_ENDERECO : S_PROXIMO_LED;
        end
      end
      S_PROXIMO_LED:       w_next = S_LEDS_ON;
      S_ZERA_ENDERECO:     w_next = S_ESPERA_JOGADA;
      S_ESPERA_JOGADA: begin
        // A play arriving on the last allowed cycle still counts.
        if (i_tem_jogada)                w_next = S_REGISTRA;
        else if (r_timer == TMAX_LAST)   w_next = S_FINAL_TIMEOUT;
      end
      S_REGISTRA:          w_next = S_COMPARACAO;
      S_COMPARACAO: begin
        if (!i_jogadaIgualMemoria)  w_next = S_FINAL_ERRO;
        else if (r_e != r_s)        w_next = S_PROXIMO;
        else if (r_s == w_last)     w_next = S_FINAL_ACERTO;
        else                        w_next = S_PROXIMA_SEQUENCIA;
      end
      S_PROXIMO:           w_next = S_ESPERA_JOGADA;
      S_PROXIMA_SEQUENCIA: w_next = S_INICIA_SEQUENCIA;
      S_INICIA_SEQUENCIA:  w_next = S_LEDS_ON;
      S_FINAL_ACERTO,
      S_FINAL_ERRO,
      S_FINAL_TIMEOUT:     if (i_iniciar) w_next = S_PREPARACAO;
      default:             w_next = S_INICIAL;
    endcase
  end

  // Single shared timer: restarts on every state change, so each timed state sees it from 0.
  assign w_timer_run = (r_state == S_LEDS_ON) || (r_state == S_LEDS_OFF) ||
                       (r_state == S_ESPERA_JOGADA);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_timer <= '0;
    end else if (w_next != r_state) begin
      r_timer <= '0;
    end else if (w_timer_run) begin
      r_timer <= r_timer + 1'b1;
    end else begin
      r_timer <= '0;
    end
  end

  // Address (E) and round-limit (S) counters; both saturate so E <= S <= last always holds.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_e <= '0;
      r_s <= '0;
    end else begin
      case (r_state)
        S_PREPARACAO: begin
          r_e <= '0;
          r_s <= '0;
        end
        S_PROXIMO_LED,
        S_PROXIMO: begin
          if (r_e != r_s) r_e <= r_e + 1'b1;
        end
        S_ZERA_ENDERECO,
        S_INICIA_SEQUENCIA: r_e <= '0;
        S_PROXIMA_SEQUENCIA: begin
          if (r_s != w_last) r_s <= r_s + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Moore output decode
  always_comb begin
    o_zeraR         = 1'b0;
    o_registraR     = 1'b0;
    o_leds_en       = 1'b0;
    o_estado_espera = 1'b0;
    o_acertou       = 1'b0;
    o_errou         = 1'b0;
    o_timeout       = 1'b0;
    o_pronto        = 1'b0;
    case (r_state)
      S_INICIAL,
      S_PREPARACAO:    o_zeraR = 1'b1;
      S_REGISTRA:      o_registraR = 1'b1;
      S_LEDS_ON:       o_leds_en = 1'b1;
      S_ESPERA_JOGADA: o_estado_espera = 1'b1;
      S_FINAL_ACERTO: begin
        o_acertou = 1'b1;
        o_pronto  = 1'b1;
      end
      S_FINAL_ERRO: begin
        o_errou  = 1'b1;
        o_pronto = 1'b1;
      end
      S_FINAL_TIMEOUT: begin
        o_errou   = 1'b1;
        o_timeout = 1'b1;
        o_pronto  = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_endereco  = r_e;
  assign o_limite    = r_s;
  assign o_db_estado = r_state;

endmodule

// File: doc/controle_sequencia_param.md
# controle_sequencia_param

Parametrised control unit for the memory-sequence game: a Moore FSM with built-in play-back timing, response timeout, sequence/address counters and optional difficulty level. It sits between the game datapath and the top level. It drives the sequence-memory address and the LED enable, and consumes the datapath's play-detect and compare flags. It removes the need for external LED-on/LED-off/timeout timers and end-of-sequence comparators.

## Interface
- ADDR_W, 4: width of address and sequence counters; maximum sequence length 2^ADDR_W.
- T_ON, 1000: cycles each sequence LED is lit during play-back (≥1).
- T_OFF, 500: dark cycles after each LED (≥1).
- T_MAX, 5000: cycles allowed per response before timeout (≥2).
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces state inicial.
- iniciar  in  1  start/restart request, level-sampled.
- nivel  in  1  difficulty: 1 = full length, 0 = half length (used only with NIVEL_EN).
- tem_jogada  in  1  one-cycle pulse: a player input is present.
- jogadaIgualMemoria  in  1  registered play equals memory[endereco].
- endereco  out  ADDR_W  sequence-memory address (counter E).
- limite  out  ADDR_W  index of the last element in the current round (counter S).
- zeraR  out  1  clear the play register.
- registraR  out  1  load the play register.
- leds_en  out  1  show memory[endereco] on the LEDs.
- estado_espera  out  1  waiting for a player input.
- acertou, errou, timeout, pronto  out  1  end flags.
- db_estado  out  4  state code, for debug.

## Operation
- State codes:
  - 0 inicial
  - 1 preparacao
  - 2 inicia_sequencia
  - 3 espera_jogada
  - 4 registra
  - 5 comparacao
  - 6 proximo
  - 8 proxima_sequencia
  - 9 leds_on
  - B leds_off
  - D proximo_led
  - F zera_endereco
  - A final_com_acerto
  - E final_com_erro
  - C final_com_timeout
- Any other code goes to inicial; db_estado = state code.
- Transitions:
  - inicial→preparacao when iniciar.
  - preparacao→leds_on. Clears E, S and R; samples nivel into an internal flag.
  - leds_on→leds_off after T_ON cycles.
  - leds_off after T_OFF cycles → zera_endereco if E==S, else proximo_led.
  - proximo_led (E+1) → leds_on.
  - zera_endereco (E=0) → espera_jogada.
  - espera_jogada → registra on tem_jogada; → final_com_timeout when the wait timer reaches T_MAX-1 with no play.
  - registra → comparacao.
  - comparacao: mismatch → final_com_erro; E≠S → proximo (E+1) → espera_jogada; E==S → final_com_acerto if S==LAST, else proxima_sequencia.
  - proxima_sequencia (S+1) → inicia_sequencia (E=0) → leds_on.
  - The three final states → preparacao when iniciar.
- LAST = 2^ADDR_W−1. With NIVEL_EN and the latched nivel=0, LAST = 2^(ADDR_W−1)−1.
- Counters never wrap: S stops at LAST, and E ≤ S always.
- Internal timer: width ceil(log2(max(T_ON,T_OFF,T_MAX))). Cleared on every state change; counts only in leds_on, leds_off and espera_jogada.
- Output decode:
  - zeraR: inicial, preparacao.
  - registraR: registra.
  - leds_en: leds_on.
  - estado_espera: espera_jogada.
  - acertou: A.
  - errou: E and C.
  - timeout: C.
  - pronto: A, E, C.

## Timing
- Reset values:
  - state inicial, E=0, S=0, timer=0.
  - zeraR=1; every other output 0; db_estado=0.
- Reset asserted mid-operation: outputs reach reset values asynchronously; no partial round resumes.
- iniciar seen at edge n puts the FSM in preparacao at n+1 and leds_on at n+2.
- Play-back per element: exactly T_ON cycles with leds_en=1, then T_OFF cycles dark.
- Between elements: 1 cycle of proximo_led. After the last element: 1 cycle of zera_endereco.
- Response: registra is entered the cycle after tem_jogada; the compare result is used one cycle later.
- tem_jogada and timer==T_MAX−1 in the same cycle: the play wins (→registra).
- tem_jogada outside espera_jogada is ignored.
- iniciar held high: each final state re-enters preparacao after 1 cycle.

## Configuration
- NIVEL_EN defined: the nivel input is honoured; it is latched in preparacao and is stable for the whole game.
- NIVEL_EN undefined: nivel is unused and LAST = 2^ADDR_W−1 always.

## Test plan
- Full win, ADDR_W=2, T_ON=3, T_OFF=2, T_MAX=8; always answer correctly → four rounds with limite 0,1,2,3.
  - Round k plays back k+1 pulses of leds_en, each 3 cycles long.
  - Ends in state A: acertou=1, pronto=1, db_estado=A.
- Same parameters, wrong answer at round 2, element 1 → final_com_erro: errou=1, timeout=0, db_estado=E, endereco=1.
- No play for 8 cycles in espera_jogada → final_com_timeout: timeout=1, errou=1, db_estado=C.
  - Also pulse tem_jogada exactly on cycle 8 of the wait → registra is entered instead.
- Assert reset during the second leds_on of round 1 → immediately state 0, leds_en=0, zeraR=1, endereco=0, limite=0.
- NIVEL_EN defined, nivel=0 at start, ADDR_W=2 → acerto after round limite=1 (2 rounds).
  - With nivel=1 → 4 rounds.
  - Toggling nivel mid-game has no effect.
- From final_com_erro, pulse iniciar → preparacao, then leds_on 1 cycle later with limite=0.
